// File: rtl/tnn_test_sequencer_if.sv
// Bundle of all non-clock signals between the TNN test sequencer and its
// environment: run control, test-vector ROM port, classifier port and the
// result stream.
//   master modport : the sequencer (drives control status, ROM address,
//                    classifier data/reset and the result stream)
//   slave modport  : the environment (start pulse, ROM data, prediction,
//                    result ready)
// Parameters must match those of the sequencer connected to it.
interface tnn_test_sequencer_if #(
    parameter int unsigned FEAT_CNT   = 12,
    parameter int unsigned HIDDEN_CNT = 40,
    parameter int unsigned FEAT_BITS  = 4,
    parameter int unsigned CLASS_CNT  = 6,
    parameter int unsigned TEST_CNT   = 1000
) ();
    localparam int unsigned CW = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1;
    localparam int unsigned IW = (TEST_CNT > 1) ? $clog2(TEST_CNT) : 1;
    localparam int unsigned DW = FEAT_BITS * FEAT_CNT;

    logic          start;
    logic          busy;
    logic          done;
    logic [IW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] dut_data;
    logic          dut_rst;
    logic [CW-1:0] dut_pred;
    logic          res_valid;
    logic          res_ready;
    logic [IW-1:0] res_index;
    logic [CW-1:0] res_class;

    modport master (
        input  start,
        output busy,
        output done,
        output mem_addr,
        input  mem_data,
        output dut_data,
        output dut_rst,
        input  dut_pred,
        output res_valid,
        input  res_ready,
        output res_index,
        output res_class
    );

    modport slave (
        output start,
        input  busy,
        input  done,
        input  mem_addr,
        output mem_data,
        input  dut_data,
        input  dut_rst,
        output dut_pred,
        input  res_valid,
        output res_ready,
        input  res_index,
        input  res_class
    );
endinterface

// File: rtl/tnn_test_sequencer.sv
// TNN test sequencer: walks a synchronous test-vector ROM, applies each
// feature vector to a serial TNN classifier, holds the classifier in reset
// while loading, waits the fixed FEAT_CNT+HIDDEN_CNT inference window, then
// captures the prediction and offers it on a valid/ready result stream.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus_io : tnn_test_sequencer_if master modport (start/busy/done, ROM
//            address/data, classifier data/reset/prediction, result stream)
// All outputs are registered.
module tnn_test_sequencer #(
    parameter int unsigned FEAT_CNT   = 12,
    parameter int unsigned HIDDEN_CNT = 40,
    parameter int unsigned FEAT_BITS  = 4,
    parameter int unsigned CLASS_CNT  = 6,
    parameter int unsigned TEST_CNT   = 1000
) (
    input logic                  clk,
    input logic                  rst_n,
    tnn_test_sequencer_if.master bus_io
);
    localparam int unsigned CW  = (CLASS_CNT > 1) ? $clog2(CLASS_CNT) : 1;
    localparam int unsigned IW  = (TEST_CNT > 1) ? $clog2(TEST_CNT) : 1;
    localparam int unsigned DW  = FEAT_BITS * FEAT_CNT;
    localparam int unsigned WIN = FEAT_CNT + HIDDEN_CNT;
    localparam int unsigned NW  = $clog2(WIN + 1);

    localparam logic [NW-1:0] WinLast = NW'(WIN - 1);
    localparam logic [IW-1:0] LastIdx = IW'(TEST_CNT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLoad,
        StRun,
        StResult,
        StFin
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] dut_data_q, dut_data_d;
    logic          dut_rst_q, dut_rst_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic          res_valid_q, res_valid_d;
    logic [IW-1:0] res_index_q, res_index_d;
    logic [CW-1:0] res_class_q, res_class_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        mem_addr_d  = mem_addr_q;
        dut_data_d  = dut_data_q;
        dut_rst_d   = dut_rst_q;
        cnt_d       = cnt_q;
        res_valid_d = res_valid_q;
        res_index_d = res_index_q;
        res_class_d = res_class_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        unique case (state_q)
            StIdle: begin
                dut_rst_d = 1'b1;
                if (bus_io.start) begin
                    idx_d      = '0;
                    mem_addr_d = '0;
                    busy_d     = 1'b1;
                    state_d    = StFetch;
                end
            end
            // One cycle for the synchronous ROM read to land.
            StFetch: begin
                dut_rst_d = 1'b1;
                state_d   = StLoad;
            end
            // dut_rst is still high this cycle; it drops together with the
            // new vector so the classifier sees clean data from its first cycle.
            StLoad: begin
                dut_data_d = bus_io.mem_data;
                dut_rst_d  = 1'b0;
                cnt_d      = '0;
                state_d    = StRun;
            end
            StRun: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == WinLast) begin
                    res_class_d = bus_io.dut_pred;
                    res_index_d = idx_q;
                    res_valid_d = 1'b1;
                    state_d     = StResult;
                end
            end
            // Classifier stays out of reset so its output holds while stalled.
            StResult: begin
                if (res_valid_q && bus_io.res_ready) begin
                    res_valid_d = 1'b0;
                    dut_rst_d   = 1'b1;
                    if (idx_q == LastIdx) begin
                        done_d  = 1'b1;
                        state_d = StFin;
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        mem_addr_d = idx_q + 1'b1;
                        state_d    = StFetch;
                    end
                end
            end
            // start is not looked at here, so a start coincident with done is dropped.
            StFin: begin
                busy_d    = 1'b0;
                dut_rst_d = 1'b1;
                state_d   = StIdle;
            end
            default: begin
                state_d   = StIdle;
                busy_d    = 1'b0;
                dut_rst_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            mem_addr_q  <= '0;
            dut_data_q  <= '0;
            dut_rst_q   <= 1'b1;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_index_q <= '0;
            res_class_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            mem_addr_q  <= mem_addr_d;
            dut_data_q  <= dut_data_d;
            dut_rst_q   <= dut_rst_d;
            cnt_q       <= cnt_d;
            res_valid_q <= res_valid_d;
            res_index_q <= res_index_d;
            res_class_q <= res_class_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus_io.busy      = busy_q;
    assign bus_io.done      = done_q;
    assign bus_io.mem_addr  = mem_addr_q;
    assign bus_io.dut_data  = dut_data_q;
    assign bus_io.dut_rst   = dut_rst_q;
    assign bus_io.res_valid = res_valid_q;
    assign bus_io.res_index = res_index_q;
    assign bus_io.res_class = res_class_q;
endmodule
